// File: rtl/oled_text_pkg.sv
// Shared types, defaults and row-search helpers for the OLED text scanner.
package oled_text_pkg;

  localparam int         OLED_ROWS      = 4;
  localparam int         DEF_COLS       = 16;
  localparam logic [7:0] DEF_BLANK_CHAR = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } scan_state_e;

  // Lowest qualifying row index at or above start (0 when none qualifies).
  function automatic logic [1:0] first_row(input logic [OLED_ROWS-1:0] mask,
                                           input logic [2:0]           start);
    logic [1:0] sel;
    sel = '0;
    for (int r = OLED_ROWS - 1; r >= 0; r--) begin
      if (mask[r] && (3'(r) >= start)) sel = 2'(r);
    end
    return sel;
  endfunction

  function automatic logic any_row(input logic [OLED_ROWS-1:0] mask,
                                   input logic [2:0]           start);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < OLED_ROWS; r++) begin
      if (mask[r] && (3'(r) >= start)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/oled_text_scanner_pick.sv
// Combinational byte selector: picks (row, col) from the snapshot and maps 8'h00 to the blank code.
module oled_char_pick
  import oled_text_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter logic [7:0] BLANK_CHAR = DEF_BLANK_CHAR
) (
  input  logic [OLED_ROWS-1:0][8*COLS-1:0] snap,
  input  logic [1:0]                       row,
  input  logic [3:0]                       col,
  output logic [7:0]                       ch
);

  logic [8*COLS-1:0] shifted;
  logic [7:0]        raw;

  // Column 0 sits in the top byte, so shifting left by col bytes brings the wanted byte to the top.
  always_comb begin
    shifted = snap[row] << {col, 3'b000};
    raw     = shifted[8*COLS-1 -: 8];
    ch      = (raw == 8'h00) ? BLANK_CHAR : raw;
  end

endmodule

// File: rtl/oled_text_scanner.sv
// Snapshots four OLED text rows on refresh and streams them char by char over valid/ready.
// Optional OLED_DIRTY_SKIP_EN: skip rows unchanged since they were last fully sent.
module oled_text_scanner
  import oled_text_pkg::*;
#(
  parameter int         COLS       = DEF_COLS,
  parameter logic [7:0] BLANK_CHAR = DEF_BLANK_CHAR
) (
  input  logic              GCLK,
  input  logic              RSTN,
  input  logic [8*COLS-1:0] OLED_S0,
  input  logic [8*COLS-1:0] OLED_S1,
  input  logic [8*COLS-1:0] OLED_S2,
  input  logic [8*COLS-1:0] OLED_S3,
  input  logic              REFRESH,
  output logic              CH_VALID,
  input  logic              CH_READY,
  output logic [7:0]        CH_DATA,
  output logic [1:0]        CH_ROW,
  output logic [3:0]        CH_COL,
  output logic              CH_LAST,
  output logic              BUSY,
  output logic              FRAME_DONE
);

  localparam logic [3:0] COL_LAST = 4'(COLS - 1);

  scan_state_e                      state_q, state_d;
  logic [OLED_ROWS-1:0][8*COLS-1:0] snap_q, snap_d;
  logic                             pending_q, pending_d;
  logic                             valid_q, valid_d;
  logic [7:0]                       data_q, data_d;
  logic [1:0]                       row_q, row_d;
  logic [3:0]                       col_q, col_d;
  logic                             last_q, last_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;

  logic [OLED_ROWS-1:0] qual_mask;
  logic                 first_found;
  logic [1:0]           first_idx;
  logic [1:0]           adv_idx;
  logic [1:0]           nxt_row;
  logic [3:0]           nxt_col;
  logic                 nxt_last;
  logic [7:0]           pick_ch;

`ifdef OLED_DIRTY_SKIP_EN
  logic [OLED_ROWS-1:0][8*COLS-1:0] shadow_q, shadow_d;
  logic                             shadow_valid_q, shadow_valid_d;

  always_comb begin
    qual_mask = '0;
    for (int r = 0; r < OLED_ROWS; r++) begin
      qual_mask[r] = !shadow_valid_q || (snap_q[r] != shadow_q[r]);
    end
  end
`else
  assign qual_mask = '1;
`endif

  // Position of the character that will be presented next, plus whether it ends the frame.
  always_comb begin
    first_found = any_row(qual_mask, 3'd0);
    first_idx   = first_row(qual_mask, 3'd0);
    adv_idx     = first_row(qual_mask, {1'b0, row_q} + 3'd1);
    if (state_q != SEND) begin
      nxt_row = first_idx;
      nxt_col = '0;
    end else if (col_q == COL_LAST) begin
      nxt_row = adv_idx;
      nxt_col = '0;
    end else begin
      nxt_row = row_q;
      nxt_col = col_q + 4'd1;
    end
    nxt_last = (nxt_col == COL_LAST) && !any_row(qual_mask, {1'b0, nxt_row} + 3'd1);
  end

  oled_char_pick #(
    .COLS      (COLS),
    .BLANK_CHAR(BLANK_CHAR)
  ) u_pick (
    .snap(snap_q),
    .row (nxt_row),
    .col (nxt_col),
    .ch  (pick_ch)
  );

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    data_d    = data_q;
    row_d     = row_q;
    col_d     = col_q;
    last_d    = last_q;
    done_d    = 1'b0;
`ifdef OLED_DIRTY_SKIP_EN
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (REFRESH || pending_q) begin
          state_d   = LOAD;
          snap_d    = {OLED_S3, OLED_S2, OLED_S1, OLED_S0};
          pending_d = 1'b0;
        end
      end
      LOAD: begin
        if (first_found) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = pick_ch;
          row_d   = nxt_row;
          col_d   = nxt_col;
          last_d  = nxt_last;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      SEND: begin
        if (CH_READY) begin
`ifdef OLED_DIRTY_SKIP_EN
          if (col_q == COL_LAST) shadow_d[row_q] = snap_q[row_q];
`endif
          if (last_q) begin
            state_d = DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = pick_ch;
            row_d  = nxt_row;
            col_d  = nxt_col;
            last_d = nxt_last;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef OLED_DIRTY_SKIP_EN
        shadow_valid_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
    if (REFRESH && (state_q != IDLE)) pending_d = 1'b1;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge GCLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      pending_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef OLED_DIRTY_SKIP_EN
      shadow_q       <= '0;
      shadow_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef OLED_DIRTY_SKIP_EN
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
`endif
    end
  end

  assign CH_VALID   = valid_q;
  assign CH_DATA    = data_q;
  assign CH_ROW     = row_q;
  assign CH_COL     = col_q;
  assign CH_LAST    = last_q;
  assign BUSY       = busy_q;
  assign FRAME_DONE = done_q;

endmodule

// File: doc/oled_text_scanner.md
# oled_text_scanner

Downstream consumer of the four 128-bit OLED text rows (`OLED_S0..OLED_S3`, 16 ASCII characters each) produced by the application logic. On a refresh request it snapshots all rows and streams them one character at a time, with row/column coordinates, over a valid/ready interface to the OLED glyph/SPI driver. Its snapshot guarantees that a frame is never torn by mid-frame text updates.

## Interface
Parameters:
- `COLS`, 16: characters per row; each row input is `8*COLS` bits wide.
- `BLANK_CHAR`, 8'h20: code emitted in place of 8'h00 bytes, which come from the zero left-padding of short string literals.

Ports:
- `GCLK`  in  1  system clock; all logic is on the rising edge.
- `RSTN`  in  1  asynchronous, active-low reset.
- `OLED_S0`..`OLED_S3`  in  8*COLS each  text rows. Row column 0 is bits [8*COLS-1 -: 8], the leftmost character.
- `REFRESH`  in  1  frame request, sampled every cycle.
- `CH_VALID`  out  1  character available.
- `CH_READY`  in  1  driver accepts the character.
- `CH_DATA`  out  8  character code after blank substitution.
- `CH_ROW`  out  2  row index, 0..3.
- `CH_COL`  out  4  column index, 0..COLS-1.
- `CH_LAST`  out  1  high with the final character of the frame.
- `BUSY`  out  1  high whenever the FSM is not in IDLE.
- `FRAME_DONE`  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: all outputs are 0. The FSM is in IDLE, the pending flag is cleared, and the shadow-valid flag is cleared.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE → LOAD when `REFRESH`=1 or the pending flag is set. All four rows are copied into a snapshot register on that edge, and the pending flag is cleared.
- LOAD selects the first row to send and sets row=that row, col=0.
  - If a row is selected, go to SEND.
  - If no row qualifies (only possible with the Configuration macro), go straight to DONE.
- SEND holds `CH_VALID`=1.
  - A transfer occurs on a cycle with `CH_VALID`&&`CH_READY`.
  - After each transfer, col increments. At col=COLS-1 it advances to the next qualifying row with col=0.
  - After the last qualifying row, go to DONE.
- DONE: `FRAME_DONE`=1 for one cycle, then back to IDLE.
- While `CH_VALID`=1 and `CH_READY`=0, `CH_DATA`, `CH_ROW`, `CH_COL` and `CH_LAST` hold stable.
- `CH_VALID` never drops without a transfer, except on reset.
- `REFRESH` while `BUSY`=1 sets the single pending flag; repeated requests coalesce into one. The new frame starts from IDLE after DONE.
- Blank substitution: a snapshot byte of 8'h00 is emitted as `BLANK_CHAR`. All other bytes pass through unchanged.
- Input changes after the snapshot have no effect on the frame in flight.
- Reset asserted mid-frame: the frame is abandoned immediately and the outputs return to their reset values. No `FRAME_DONE` is produced.

## Timing
- `REFRESH` sampled at edge k (in IDLE): LOAD during cycle k..k+1, and `CH_VALID`=1 after edge k+1.
- With `CH_READY` held high, throughput is one character per cycle. A full frame is 4*COLS = 64 transfers.
- `FRAME_DONE` pulses in the cycle after the `CH_LAST` transfer.
- The earliest next frame is 2 cycles after DONE (DONE→IDLE→LOAD). With the pending flag set, LOAD follows IDLE directly.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `OLED_DIRTY_SKIP_EN` defined:
  - A shadow copy holds the last fully sent rows.
  - LOAD and the row advance skip rows whose snapshot equals the shadow.
  - The shadow updates per row when that row's last character transfers.
  - The shadow-valid flag is set at the first DONE. Until then, all rows qualify.
- `OLED_DIRTY_SKIP_EN` not defined: every frame sends all 4 rows. No shadow storage is built.

## Structure
- Package `oled_text_pkg`:
  - `OLED_ROWS`=4
  - default `COLS` and `BLANK_CHAR`
  - FSM state enum (IDLE, LOAD, SEND, DONE)
- Sub-module `oled_char_pick`: purely combinational. It selects the byte at (row, col) from the snapshot and applies blank substitution. Its output feeds the registered `CH_DATA`.

## Test plan
- Reset, then `S0`="SPI interface", `S1`=".", `S2`=".", `S3`="----------------", `REFRESH` pulse, `CH_READY`=1 → 64 transfers.
  - Row 0, cols 0-2 = 8'h20, col 3 = 8'h53 ('S').
  - Row 1, col 15 = 8'h2E.
  - Row 3, all cols = 8'h2D.
  - `CH_LAST` only at (3,15); `FRAME_DONE` one cycle after it.
- `CH_READY` toggling 1010… during a frame → each character held stable until accepted; no loss or duplication; 64 transfers total.
- Change `S0` to "X" at the 5th transfer → the remaining row-0 characters still come from "SPI interface".
- `REFRESH` pulsed three times while `BUSY` → exactly one extra frame follows; two `FRAME_DONE` pulses total.
- `RSTN` low at the 20th transfer → `CH_VALID`=0 and `BUSY`=0 asynchronously; no `FRAME_DONE`; the next `REFRESH` starts at (0,0).
- With `OLED_DIRTY_SKIP_EN`: first frame sends 64 characters.
  - Change only `S2`, then `REFRESH` → 16 transfers, all with row=2.
  - Refresh again with no change → no `CH_VALID`; `FRAME_DONE` 2 cycles after `REFRESH`.
